// File: rtl/imem_loader_if.sv
// Host-to-loader word stream plus the instruction-memory port A bus.
// Handshake: a host word transfers on a rising clk edge where host_valid_i && host_ready_o; the host holds data/last stable until then, and ready never depends on valid.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  host_valid_i;
  logic [DATA_WIDTH-1:0] host_data_i;
  logic                  host_last_i;
  logic                  host_ready_o;
  logic                  imem_wea_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_dina_o;
  logic [DATA_WIDTH-1:0] imem_douta_i;

  modport slave (
    input  host_valid_i, host_data_i, host_last_i, imem_douta_i,
    output host_ready_o, imem_wea_o, imem_addr_o, imem_dina_o
  );

  modport master (
    output host_valid_i, host_data_i, host_last_i, imem_douta_i,
    input  host_ready_o, imem_wea_o, imem_addr_o, imem_dina_o
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a host image into instruction memory, reads it back to compare
// checksums, and holds the CPU in reset until the image is proven good.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  imem_loader_if.slave          bus,
  output logic                  cpu_rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_VERIFY  = 3'd2,
    S_DONE_OK = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_t                state_q;
  logic [ADDR_WIDTH:0]   word_count_q;
  logic [ADDR_WIDTH:0]   vcnt_q;
  logic [DATA_WIDTH-1:0] write_sum_q;
  logic [DATA_WIDTH-1:0] read_sum_q;
  logic [1:0]            err_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cpu_rst_n_q;

  logic                  accept;
  logic                  last_addr;
  logic                  verify_end;
  logic                  mismatch;
  logic [DATA_WIDTH-1:0] read_sum_nxt;
  logic [ADDR_WIDTH-1:0] addr_c;

  assign accept       = bus.host_valid_i && (state_q == S_LOAD);
  assign last_addr    = (word_count_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
  assign read_sum_nxt = read_sum_q + bus.imem_douta_i;
  assign verify_end   = (state_q == S_VERIFY) && (vcnt_q == word_count_q);
  assign mismatch     = (read_sum_nxt != write_sum_q);

  // Loading writes at the running count; verify walks 0..count-1 and then
  // spends one extra cycle collecting the last read word.
  always_comb begin
    addr_c = '0;
    if (state_q == S_LOAD) begin
      addr_c = word_count_q[ADDR_WIDTH-1:0];
    end else if ((state_q == S_VERIFY) && (vcnt_q < word_count_q)) begin
      addr_c = vcnt_q[ADDR_WIDTH-1:0];
    end
  end

  assign bus.host_ready_o = (state_q == S_LOAD);
  assign bus.imem_wea_o   = accept;
  assign bus.imem_addr_o  = addr_c;
  assign bus.imem_dina_o  = accept ? bus.host_data_i : '0;

  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = word_count_q;
  assign state_o      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_count_q <= '0;
      vcnt_q       <= '0;
      write_sum_q  <= '0;
      read_sum_q   <= '0;
      err_q        <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_rst_n_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE_OK, S_FAIL: begin
          if (load_start_i) begin
            state_q      <= S_LOAD;
            word_count_q <= '0;
            vcnt_q       <= '0;
            write_sum_q  <= '0;
            read_sum_q   <= '0;
            err_q        <= 2'b00;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
          end
        end

        S_LOAD: begin
          if (accept) begin
            word_count_q <= word_count_q + CNT_ONE;
            write_sum_q  <= write_sum_q + bus.host_data_i;
            // The top address is the last slot: without a last marker the
            // image is too big, so stop here rather than wrap.
            if (bus.host_last_i || last_addr) begin
              state_q    <= S_VERIFY;
              vcnt_q     <= '0;
              read_sum_q <= '0;
              if (!bus.host_last_i) begin
                err_q[1] <= 1'b1;
              end
            end
          end
        end

        S_VERIFY: begin
          vcnt_q <= vcnt_q + CNT_ONE;
          if (vcnt_q != '0) begin
            read_sum_q <= read_sum_nxt;
          end
          if (verify_end) begin
            err_q[0] <= mismatch;
            busy_q   <= 1'b0;
            if (err_q[1] || mismatch) begin
              state_q <= S_FAIL;
              done_q  <= 1'b0;
            end else begin
              state_q     <= S_DONE_OK;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          cpu_rst_n_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads against a behavioural RAM and an
// image-level model of writes, verify traffic and final status.
module tb_imem_loader;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int AW2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW)) if8 ();
  imem_loader_if #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW)) if2 ();

  logic          start8, start2;
  logic          cpu_rst_n8, busy8, done8;
  logic          cpu_rst_n2, busy2, done2;
  logic [1:0]    err8, err2;
  logic [AW:0]   wc8;
  logic [AW2:0]  wc2;
  logic [2:0]    st8, st2;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut8 (
    .clk(clk), .rst(rst), .load_start_i(start8), .bus(if8.slave),
    .cpu_rst_n_o(cpu_rst_n8), .busy_o(busy8), .done_o(done8),
    .err_o(err8), .word_count_o(wc8), .state_o(st8)
  );

  imem_loader #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW)) dut2 (
    .clk(clk), .rst(rst), .load_start_i(start2), .bus(if2.slave),
    .cpu_rst_n_o(cpu_rst_n2), .busy_o(busy2), .done_o(done2),
    .err_o(err2), .word_count_o(wc2), .state_o(st2)
  );

  // ---------------- behavioural RAMs (1-cycle read) ----------------
  logic [DW-1:0] mem8 [2**AW];
  logic [DW-1:0] mem2 [2**AW2];
  int            corrupt8 = -1;

  always @(posedge clk) begin
    if (if8.imem_wea_o) mem8[if8.imem_addr_o] <= if8.imem_dina_o;
    if8.imem_douta_i <= mem8[if8.imem_addr_o] ^
                        ((int'(if8.imem_addr_o) == corrupt8) ? 32'd1 : 32'd0);
  end

  always @(posedge clk) begin
    if (if2.imem_wea_o) mem2[if2.imem_addr_o] <= if2.imem_dina_o;
    if2.imem_douta_i <= mem2[if2.imem_addr_o];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]    sent_q[$];
  logic [AW+DW-1:0] exp_q[$];
  int vk   = 0;
  int vcyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare for the 8-bit instance.
  always @(negedge clk) begin : mon
    logic             acc;
    logic [AW+DW-1:0] e;
    if (!rst) begin
      acc = if8.host_valid_i && if8.host_ready_o;
      check("cpu_rst_n_vs_status", cpu_rst_n8, !(busy8 || (err8 != 2'b00)));
      check("wea_eq_accept", if8.imem_wea_o, acc);
      if (if8.imem_wea_o) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", if8.imem_addr_o, e[AW+DW-1:DW]);
          check("wr_data", if8.imem_dina_o, e[DW-1:0]);
        end
      end
      if (busy8 && !if8.host_ready_o) begin
        vcyc++;
        if (vk < sent_q.size()) begin
          check("verify_addr", if8.imem_addr_o, vk);
          vk++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_start8(input bit reset_model);
    @(posedge clk); #1;
    start8 = 1'b1;
    if (reset_model) begin
      sent_q.delete();
      vk   = 0;
      vcyc = 0;
    end
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic send8(input logic [DW-1:0] d, input bit last);
    int n;
    exp_q.push_back({AW'(sent_q.size()), d});
    sent_q.push_back(d);
    if8.host_valid_i = 1'b1;
    if8.host_data_i  = d;
    if8.host_last_i  = last;
    n = 0;
    @(negedge clk);
    while (!if8.host_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", n < 50, 1);
    @(posedge clk); #1;
    if8.host_valid_i = 1'b0;
    if8.host_last_i  = 1'b0;
    if8.host_data_i  = '0;
  endtask

  // Waits for DONE_OK/FAIL, then checks status against the image model.
  task automatic wait_end8();
    int            n;
    int            wc;
    logic [DW-1:0] wsum, rsum;
    logic [1:0]    merr;
    n = 0;
    @(negedge clk);
    while ((!(done8 || (err8 != 2'b00)) || busy8) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("end_in_time", n < 2000, 1);
    wc   = sent_q.size();
    wsum = '0;
    rsum = '0;
    for (int i = 0; i < wc; i++) begin
      wsum += sent_q[i];
      rsum += (i == corrupt8) ? (sent_q[i] ^ 32'd1) : sent_q[i];
    end
    merr = {1'b0, rsum != wsum};
    check("word_count", wc8, wc);
    check("err", err8, merr);
    check("done", done8, merr == 2'b00);
    check("verify_cycles", vcyc, wc + 1);
    check("writes_drained", exp_q.size(), 0);
    check("cpu_rst_n_end", cpu_rst_n8, merr == 2'b00);
  endtask

  task automatic check_reset8(input string tag);
    check({tag, "_ready"}, if8.host_ready_o, 0);
    check({tag, "_wea"}, if8.imem_wea_o, 0);
    check({tag, "_addr"}, if8.imem_addr_o, 0);
    check({tag, "_dina"}, if8.imem_dina_o, 0);
    check({tag, "_cpu_rst_n"}, cpu_rst_n8, 1);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_done"}, done8, 0);
    check({tag, "_err"}, err8, 0);
    check({tag, "_wc"}, wc8, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    start8 = 1'b0; start2 = 1'b0;
    if8.host_valid_i = 1'b0; if8.host_data_i = '0; if8.host_last_i = 1'b0;
    if2.host_valid_i = 1'b0; if2.host_data_i = '0; if2.host_last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset8("por");
    check("por2_cpu_rst_n", cpu_rst_n2, 1);
    check("por2_wc", wc2, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy8, 0);
    check("idle_ready", if8.host_ready_o, 0);

    // Normal four-word load.
    pulse_start8(1);
    check("load_entry_cpu_rst_n", cpu_rst_n8, 0);
    check("load_entry_ready", if8.host_ready_o, 1);
    send8(32'h11, 0);
    send8(32'h22, 0);
    send8(32'h33, 0);
    send8(32'h44, 1);
    wait_end8();
    check("t1_wc_lit", wc8, 4);
    check("t1_err_lit", err8, 2'b00);
    check("t1_done_lit", done8, 1);
    check("t1_vcyc_lit", vcyc, 5);
    check("t1_mem0", mem8[0], 32'h11);
    check("t1_mem1", mem8[1], 32'h22);
    check("t1_mem2", mem8[2], 32'h33);
    check("t1_mem3", mem8[3], 32'h44);

    // Valid toggling 1,0,1,0.
    pulse_start8(1);
    send8(32'hA5, 0);
    @(posedge clk); #1;
    send8(32'h5A, 1);
    wait_end8();
    check("t2_wc_lit", wc8, 2);
    check("t2_mem0", mem8[0], 32'hA5);
    check("t2_mem1", mem8[1], 32'h5A);

    // Readback of address 2 corrupted.
    corrupt8 = 2;
    pulse_start8(1);
    send8(32'h1, 0);
    send8(32'h2, 0);
    send8(32'h3, 0);
    send8(32'h4, 1);
    wait_end8();
    check("t3_err_lit", err8, 2'b01);
    check("t3_done_lit", done8, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_err_hold", err8, 2'b01);
    check("t3_cpu_hold", cpu_rst_n8, 0);
    corrupt8 = -1;

    // Start pulse during VERIFY is ignored.
    pulse_start8(1);
    send8(32'h7, 0);
    send8(32'h8, 0);
    send8(32'h9, 1);
    pulse_start8(0);
    wait_end8();
    check("t4_wc_lit", wc8, 3);
    check("t4_done_lit", done8, 1);

    // Reset in the middle of a load.
    pulse_start8(1);
    send8(32'hDEAD0001, 0);
    send8(32'hDEAD0002, 0);
    #3;
    rst = 1'b1;
    #1;
    check_reset8("midrst");
    sent_q.delete();
    exp_q.delete();
    vk = 0;
    vcyc = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy", busy8, 0);
    check("postrst_cpu_rst_n", cpu_rst_n8, 1);
    pulse_start8(1);
    send8(32'hBEEF, 1);
    wait_end8();
    check("t5_wc_lit", wc8, 1);
    check("t5_done_lit", done8, 1);

    // Overflow on the 4-deep instance: five words, none marked last.
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if2.host_valid_i = 1'b1;
      if2.host_data_i  = DW'(i + 1);
      if2.host_last_i  = 1'b0;
      @(negedge clk);
      check("ovf_ready", if2.host_ready_o, i < 4);
      check("ovf_wea", if2.imem_wea_o, i < 4);
      if (i < 4) check("ovf_addr", if2.imem_addr_o, i);
      @(posedge clk); #1;
    end
    if2.host_valid_i = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovf_end_in_time", n < 100, 1);
    check("ovf_err", err2, 2'b10);
    check("ovf_done", done2, 0);
    check("ovf_wc", wc2, 4);
    check("ovf_cpu_rst_n", cpu_rst_n2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the instruction-memory word-address width (DEPTH = 2^ADDR_WIDTH).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port load_start_i, input, 1: one-cycle pulse that begins a load.
REQ-007 Port host_valid_i, input, 1: host word valid.
REQ-008 Port host_data_i, input, DATA_WIDTH: host instruction word.
REQ-009 Port host_last_i, input, 1: marks the final word of the image.
REQ-010 Port host_ready_o, output, 1: loader accepts a word when host_valid_i && host_ready_o.
REQ-011 Port imem_wea_o, output, 1: instruction-memory write enable.
REQ-012 Port imem_addr_o, output, ADDR_WIDTH: instruction-memory word address.
REQ-013 Port imem_dina_o, output, DATA_WIDTH: instruction-memory write data.
REQ-014 Port imem_douta_i, input, DATA_WIDTH: instruction-memory read data, valid one cycle after the address is presented.
REQ-015 Port cpu_rst_n_o, output, 1: active-low CPU hold; 0 holds the CPU in reset.
REQ-016 Port busy_o, output, 1: high in LOAD or VERIFY.
REQ-017 Port done_o, output, 1: high in DONE_OK.
REQ-018 Port err_o, output, 2: bit0 = checksum mismatch, bit1 = overflow (image reached DEPTH words without host_last_i).
REQ-019 Port word_count_o, output, ADDR_WIDTH+1: number of words written in the current or last load.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, VERIFY, DONE_OK and FAIL.
REQ-021 IDLE -> LOAD SHALL occur on load_start_i; the transition clears word_count_o, the running sums and err_o.
REQ-022 load_start_i SHALL be ignored in LOAD and VERIFY.
REQ-023 load_start_i SHALL start a new load from DONE_OK or FAIL.
REQ-024 host_ready_o SHALL be 1 only in LOAD.
REQ-025 On each accepted word, in the same cycle, the block SHALL drive:
- imem_wea_o = 1
- imem_addr_o = word_count_o[ADDR_WIDTH-1:0]
- imem_dina_o = host_data_i
REQ-026 On each accepted word the block SHALL, at the next edge, increment word_count_o and add the word to a DATA_WIDTH-bit write sum (modulo 2^DATA_WIDTH).
REQ-027 imem_wea_o SHALL be 0 in every cycle without an accepted word.
REQ-028 An accepted word with host_last_i = 1 SHALL move the FSM to VERIFY at the next edge.
REQ-029 An accepted word at address DEPTH-1 with host_last_i = 0 SHALL set err_o[1] and move the FSM to VERIFY; no address wrap SHALL occur.
REQ-030 In VERIFY, imem_wea_o SHALL be 0.
REQ-031 In VERIFY, the block SHALL present addresses 0 .. word_count_o-1, one per cycle.
REQ-032 In VERIFY, each imem_douta_i SHALL be captured one cycle after its address and added to a read sum.
REQ-033 VERIFY SHALL last exactly word_count_o+1 cycles.
REQ-034 At the end of VERIFY:
- err_o[0] SHALL be set if the read sum differs from the write sum
- the FSM SHALL go to DONE_OK if err_o == 0, else to FAIL
REQ-035 cpu_rst_n_o SHALL be registered.
REQ-036 cpu_rst_n_o SHALL be 1 in IDLE and DONE_OK, and 0 in LOAD, VERIFY and FAIL.
REQ-037 cpu_rst_n_o SHALL go low on the edge entering LOAD.
REQ-038 done_o, err_o and word_count_o SHALL hold until the next load_start_i.

Reset
REQ-039 rst SHALL asynchronously force the following, at any time including mid-LOAD or mid-VERIFY:
- state IDLE
- host_ready_o = 0, imem_wea_o = 0, imem_addr_o = 0, imem_dina_o = 0
- cpu_rst_n_o = 1, busy_o = 0, done_o = 0
- err_o = 0, word_count_o = 0, both sums = 0
REQ-040 After rst deasserts, the block SHALL remain in IDLE until load_start_i.

Verification
REQ-041 Normal load: pulse start, send 4 words 0x11,0x22,0x33,0x44 (last on 4th), model RAM -> 4 writes to addr 0-3, VERIFY 5 cycles, done_o = 1, err_o = 0, word_count_o = 4, cpu_rst_n_o low from LOAD entry until DONE_OK.
REQ-042 Backpressure/gaps: host_valid_i toggles 1,0,1,0 -> writes occur only on valid cycles; addresses contiguous 0,1; no write on idle cycles.
REQ-043 Corrupted RAM: model flips bit 0 of addr 2 on readback -> err_o = 2'b01, FAIL, cpu_rst_n_o stays 0.
REQ-044 Overflow with ADDR_WIDTH = 2: 5 words sent, no last -> 4 words accepted, host_ready_o = 0 after the 4th, err_o = 2'b10, FAIL, word_count_o = 4.
REQ-045 Reset mid-LOAD after 2 words -> all outputs at reset values, cpu_rst_n_o = 1; a subsequent load of 1 word with last -> DONE_OK, word_count_o = 1.
REQ-046 Start ignored: load_start_i pulsed during VERIFY -> no count/sum clear, normal DONE_OK completion.
